// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// The func3 encodings are shared between loads and stores, so the store names alias the load ones.
package lsu_pkg;

  localparam logic [6:0] MEM_RD_OP = 7'b0000011;
  localparam logic [6:0] MEM_WR_OP = 7'b0100011;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } func3_t;

  localparam func3_t SB = LB;
  localparam func3_t SH = LH;
  localparam func3_t SW = LW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for RV32I accesses.
// Produces byte enables, replicated write data and the extended load result, plus legality flags.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Size/sign decode for both directions; unknown encodings flag illegal.
  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0000_0000;
    load_data  = 32'h0000_0000;
    misaligned = 1'b0;
    illegal    = 1'b0;
    if (is_store) begin
      case (func3)
        SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        SH: begin
          be         = 4'b0011 << {addr_lo[1], 1'b0};
          wdata      = {2{store_data[15:0]}};
          misaligned = addr_lo[0];
        end
        SW: begin
          be         = 4'b1111;
          wdata      = store_data;
          misaligned = |addr_lo;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      be = 4'b1111;
      case (func3)
        LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
        LBU: load_data = {24'h00_0000, shifted[7:0]};
        LH: begin
          load_data  = {{16{shifted[15]}}, shifted[15:0]};
          misaligned = addr_lo[0];
        end
        LHU: begin
          load_data  = {16'h0000, shifted[15:0]};
          misaligned = addr_lo[0];
        end
        LW: begin
          load_data  = rdata;
          misaligned = |addr_lo;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/REQ/WAIT/DONE sequencer around a valid/grant data bus.
// Bus outputs are registered at accept and held until grant; lane logic lives in lsu_align.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             stall,
  output logic             done,
  output logic             load_valid,
  output logic [WIDTH-1:0] load_data,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  lsu_state_t  state, next_state;
  logic        is_load_op, is_store_op, accept, bad;
  logic        op_store_r;
  logic [2:0]  func3_r;
  logic [1:0]  addr_lo_r;
  logic        sel_store;
  logic [2:0]  sel_func3;
  logic [1:0]  sel_addr_lo;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, ld_s;
  logic        misaligned_s, illegal_s;

  assign is_load_op  = (opcode == MEM_RD_OP);
  assign is_store_op = (opcode == MEM_WR_OP);
  assign accept      = !rst && (state == ST_IDLE) && req_valid && (is_load_op || is_store_op);
  assign bad         = misaligned_s | illegal_s;

  // Live inputs drive the decode while idle; afterwards the latched copy steers load extraction.
  assign sel_store   = (state == ST_IDLE) ? is_store_op : op_store_r;
  assign sel_func3   = (state == ST_IDLE) ? func3 : func3_r;
  assign sel_addr_lo = (state == ST_IDLE) ? addr[1:0] : addr_lo_r;

  assign stall = accept | (state == ST_REQ) | (state == ST_WAIT);

  lsu_align u_align (
    .is_store   (sel_store),
    .func3      (sel_func3),
    .addr_lo    (sel_addr_lo),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_data  (ld_s),
    .misaligned (misaligned_s),
    .illegal    (illegal_s)
  );

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = bad ? ST_DONE : ST_REQ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          next_state = op_store_r ? ST_DONE : ST_WAIT;
        end else begin
          next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register, latched request fields and registered bus/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_store_r <= 1'b0;
      func3_r    <= 3'b000;
      addr_lo_r  <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
      load_data  <= '0;
      done       <= 1'b0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= next_state;
      mem_req    <= (next_state == ST_REQ);
      done       <= (next_state == ST_DONE);
      fault      <= accept && bad;
      load_valid <= (state == ST_WAIT) && mem_rvalid;
      if (accept) begin
        op_store_r <= is_store_op;
        func3_r    <= func3;
        addr_lo_r  <= addr[1:0];
      end
      if (accept && !bad) begin
        mem_addr  <= {addr[WIDTH-1:2], 2'b00};
        mem_we    <= is_store_op;
        mem_be    <= be_s;
        mem_wdata <= is_store_op ? wdata_s : '0;
      end
      if ((state == ST_WAIT) && mem_rvalid) begin
        load_data <= ld_s;
      end
    end
  end

endmodule
